restoring_divider_64bit: RTL and testbench

RESTORING_DIVIDER_64BIT -- requirements
Module: restoring_divider_64bit

---
 rtl/alu_pkg.sv | 20 ++
 rtl/subtractor_64bit.sv | 18 +
 rtl/restoring_divider_64bit.sv | 119 +++++++++++
 tb/tb_restoring_divider_64bit.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU blocks: divider FSM state encoding, the default
// operand width and the width of the divider iteration counter.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

  localparam int DIV_WIDTH = 64;

  // The counter has to reach WIDTH itself, hence the extra bit.
  function automatic int div_cnt_w(input int width);
    return $clog2(width) + 1;
  endfunction

  localparam int DIV_CNT_W = div_cnt_w(DIV_WIDTH);

endpackage

// File: rtl/subtractor_64bit.sv
// Combinational ripple subtractor: diff = a - b - c_in, c_out is the borrow out.
module subtractor_64bit #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic [WIDTH-1:0] diff,
  output logic             c_out
);

  logic [WIDTH:0] full;

  assign full  = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, c_in};
  assign diff  = full[WIDTH-1:0];
  assign c_out = full[WIDTH];

endmodule

// File: rtl/restoring_divider_64bit.sv
// Unsigned restoring divider: one quotient bit per cycle, MSB first, followed by
// a single-cycle DONE pulse. A zero divisor skips RUN and reports div_by_zero.
module restoring_divider_64bit
  import alu_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = div_cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH);

  div_state_e state;
  div_state_e next_state;

  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dvs;

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] trial_diff;
  logic             low_borrow;
  logic             accept;
  logic [WIDTH-1:0] rem_next;

  // dvd_q shifts dividend bits out of the top while quotient bits enter at the bottom.
  assign shifted = {rem, dvd_q[WIDTH-1]};

  subtractor_64bit #(
    .WIDTH (WIDTH)
  ) u_sub (
    .a     (shifted[WIDTH-1:0]),
    .b     (dvs),
    .c_in  (1'b0),
    .diff  (trial_diff),
    .c_out (low_borrow)
  );

  // A set MSB in the shifted value absorbs the low-part borrow, so no borrow at WIDTH+1 bits.
  assign accept   = shifted[WIDTH] | ~low_borrow;
  assign rem_next = accept ? trial_diff : shifted[WIDTH-1:0];

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          next_state = (divisor == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (cnt == LAST) begin
          next_state = DONE;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      dvd_q       <= '0;
      rem         <= '0;
      dvs         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state <= next_state;
      unique case (state)
        IDLE: begin
          if (start) begin
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              dvd_q       <= dividend;
              dvs         <= divisor;
              rem         <= '0;
              cnt         <= '0;
              div_by_zero <= 1'b0;
            end
          end
        end
        RUN: begin
          if (cnt != LAST) begin
            dvd_q <= {dvd_q[WIDTH-2:0], accept};
            rem   <= rem_next;
            cnt   <= cnt + 1'b1;
          end else begin
            quotient  <= dvd_q;
            remainder <= rem;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_restoring_divider_64bit.sv
// Scoreboard bench for restoring_divider_64bit: directed operands with hand-computed
// quotient/remainder and expected done cycle, checked by an independent monitor.
module tb_restoring_divider_64bit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [63:0] dividend;
  logic [63:0] divisor;
  logic        busy;
  logic        done;
  logic [63:0] quotient;
  logic [63:0] remainder;
  logic        div_by_zero;

  restoring_divider_64bit #(.WIDTH(64)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] q;
    logic [63:0] r;
    logic        dz;
    int          done_cyc;
  } exp_t;

  exp_t sb[$];
  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_done: done=1 with no outstanding operation (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("quotient", quotient, e.q);
        check("remainder", remainder, e.r);
        check("div_by_zero", {63'd0, div_by_zero}, {63'd0, e.dz});
        check("done_cycle", 64'(cyc), 64'(e.done_cyc));
        check("busy_in_done", {63'd0, busy}, 64'd1);
      end
    end
  end

  // Issue one operation; the accepting edge is the next posedge (cyc+1).
  task automatic issue(input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] q, input logic [63:0] r);
    exp_t e;
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    e.q  = q;
    e.r  = r;
    e.dz = (b == 64'd0);
    e.done_cyc = cyc + 1 + ((b == 64'd0) ? 0 : 65);
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", {63'd0, busy}, 64'd1);
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 150; k++) begin
      @(negedge clk);
      if (sb.size() == 0 && busy === 1'b0) break;
    end
    if (k >= 150) begin
      n_chk++;
      n_fail++;
      $display("FAIL timeout: %0d operations outstanding after bound", sb.size());
      sb.delete();
    end
  endtask

  task automatic run_op(input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] q, input logic [63:0] r);
    issue(a, b, q, r);
    wait_idle();
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_quotient", quotient, 64'd0);
    check("rst_remainder", remainder, 64'd0);
    check("rst_dbz", {63'd0, div_by_zero}, 64'd0);
    rst = 1'b0;

    // Directed vectors
    run_op(64'd900000,  64'd738468,  64'd1, 64'd161532);
    run_op(64'd7446525, 64'd1000000, 64'd7, 64'd446525);
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0);
    run_op(64'd5,    64'd9,  64'd0,   64'd5);
    run_op(64'd100,  64'd7,  64'd14,  64'd2);
    run_op(64'd1000, 64'd10, 64'd100, 64'd0);
    run_op(64'd0,    64'd5,  64'd0,   64'd0);
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0);
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF);
    run_op(64'h8000_0000_0000_0000, 64'd2, 64'h4000_0000_0000_0000, 64'd0);

    // Divide by zero, then results hold while idle
    run_op(64'd1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1234);
    repeat (5) @(negedge clk);
    check("dbz_hold_q", quotient, 64'hFFFF_FFFF_FFFF_FFFF);
    check("dbz_hold_r", remainder, 64'd1234);
    check("dbz_hold_flag", {63'd0, div_by_zero}, 64'd1);

    // Next accepted start clears div_by_zero
    run_op(64'd50, 64'd8, 64'd6, 64'd2);

    // Start and operand changes during RUN are ignored
    issue(64'd900000, 64'd738468, 64'd1, 64'd161532);
    repeat (9) @(negedge clk);
    dividend = 64'd42;
    divisor  = 64'd5;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    dividend = 64'd77;
    divisor  = 64'd3;
    wait_idle();
    repeat (80) @(negedge clk);
    check("ignored_start_hold_q", quotient, 64'd1);
    check("ignored_start_hold_r", remainder, 64'd161532);
    check("ignored_start_idle", {63'd0, busy}, 64'd0);

    // Reset aborts an operation in flight; no done may follow
    issue(64'd123456789, 64'd1000, 64'd0, 64'd0);
    repeat (29) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    sb.delete();
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_done", {63'd0, done}, 64'd0);
    check("abort_quotient", quotient, 64'd0);
    check("abort_remainder", remainder, 64'd0);
    check("abort_dbz", {63'd0, div_by_zero}, 64'd0);
    rst = 1'b0;
    repeat (80) @(negedge clk);
    run_op(64'd123456789, 64'd1000, 64'd123456, 64'd789);

    // Start issued in the same cycle reset drops is accepted on the next edge
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    begin
      exp_t e;
      dividend = 64'd99;
      divisor  = 64'd10;
      start    = 1'b1;
      e.q = 64'd9;
      e.r = 64'd9;
      e.dz = 1'b0;
      e.done_cyc = cyc + 66;
      sb.push_back(e);
      @(negedge clk);
      start = 1'b0;
      check("post_rst_accept", {63'd0, busy}, 64'd1);
    end
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
